// File: rtl/dmem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller: FSM state
// encodings, the default abort timeout and the timeout counter helper.
package dmem_access_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CPU_ACC  = 3'd1,
        S_CPU_RESP = 3'd2,
        S_DBG_ACC  = 3'd3,
        S_DBG_RESP = 3'd4
    } state_t;

    localparam int TIMEOUT_DEFAULT = 15;
    localparam int CNT_W           = 8;

    // Saturating increment so a very long wait never wraps back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_rr_arb.sv
// Two-way round-robin select between the CPU and the debug port.
// A lone requester always wins; on a tie the side that did not win last goes.
module dmem_rr_arb (
    input  logic cpu_req,
    input  logic dbg_req,
    input  logic last_dbg,
    output logic any_req,
    output logic sel_dbg
);

    // Pure combinational select; the owner of last_dbg updates it on grant.
    always_comb begin
        any_req = cpu_req | dbg_req;
        sel_dbg = dbg_req & (~cpu_req | ~last_dbg);
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access sequencer. Serialises CPU loads/stores and
// debug commands onto one req/ack bus, aborts accesses that never see an
// ack, and stalls the upstream pipeline while a CPU access is pending.
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          mem_isValid,
    input  logic          mem_mem_read,
    input  logic          mem_mem_write,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_sData,
    output logic          stall,
    output logic          mem_done,
    output logic          mem_err,
    output logic [DW-1:0] mem_lData,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_done,
    output logic          dbg_err,
    output logic [DW-1:0] dbg_rdata,
    output logic          bus_req,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic          bus_ack,
    input  logic [DW-1:0] bus_rdata,
    output logic          bus_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t           state;
    logic             last_dbg;
    logic [CNT_W-1:0] count;
    logic             cpu_req;
    logic             any_req;
    logic             sel_dbg;
    logic             in_acc;
    logic             acc_is_cpu;

    dmem_rr_arb u_arb (
        .cpu_req  (cpu_req),
        .dbg_req  (dbg_req),
        .last_dbg (last_dbg),
        .any_req  (any_req),
        .sel_dbg  (sel_dbg)
    );

    // Request decode and the combinational handshake outputs.
    always_comb begin
        cpu_req    = mem_isValid & (mem_mem_read | mem_mem_write);
        stall      = cpu_req & (state != S_CPU_RESP);
        dbg_gnt    = (state == S_IDLE) & sel_dbg;
        in_acc     = (state == S_CPU_ACC) | (state == S_DBG_ACC);
        acc_is_cpu = (state == S_CPU_ACC);
    end

    // Access FSM with bus latches, result registers and timeout counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            last_dbg  <= 1'b1;
            count     <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_err   <= 1'b0;
            mem_done  <= 1'b0;
            mem_err   <= 1'b0;
            mem_lData <= '0;
            dbg_done  <= 1'b0;
            dbg_err   <= 1'b0;
            dbg_rdata <= '0;
        end else begin
            // Completion flags are single-cycle pulses.
            mem_done <= 1'b0;
            mem_err  <= 1'b0;
            dbg_done <= 1'b0;
            dbg_err  <= 1'b0;
            bus_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        count    <= '0;
                        bus_req  <= 1'b1;
                        last_dbg <= sel_dbg;
                        if (sel_dbg) begin
                            bus_addr  <= dbg_addr;
                            bus_we    <= dbg_we;
                            bus_wdata <= dbg_wdata;
                            state     <= S_DBG_ACC;
                        end else begin
                            bus_addr  <= mem_addr;
                            bus_we    <= mem_mem_write;
                            bus_wdata <= mem_sData;
                            state     <= S_CPU_ACC;
                        end
                    end
                end
                S_CPU_ACC, S_DBG_ACC: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (acc_is_cpu) begin
                            if (!bus_we) mem_lData <= bus_rdata;
                            mem_done <= 1'b1;
                            state    <= S_CPU_RESP;
                        end else begin
                            if (!bus_we) dbg_rdata <= bus_rdata;
                            dbg_done <= 1'b1;
                            state    <= S_DBG_RESP;
                        end
                    end else if (in_acc && count == CNT_LAST) begin
                        // Abort: a slave that never answers must not hang the core.
                        bus_req <= 1'b0;
                        bus_err <= 1'b1;
                        if (acc_is_cpu) begin
                            mem_lData <= '0;
                            mem_done  <= 1'b1;
                            mem_err   <= 1'b1;
                            state     <= S_CPU_RESP;
                        end else begin
                            dbg_rdata <= '0;
                            dbg_done  <= 1'b1;
                            dbg_err   <= 1'b1;
                            state     <= S_DBG_RESP;
                        end
                    end else begin
                        count <= sat_inc(count);
                    end
                end
                // The pipeline advances on this edge, so IDLE sees the next instruction.
                S_CPU_RESP, S_DBG_RESP: state <= S_IDLE;
                default:                state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: combinational vector table,
// directed multi-cycle sequences and a randomized run against a
// transaction-level model of the bus sharing protocol.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_isValid, mem_mem_read, mem_mem_write;
    logic [31:0] mem_addr, mem_sData;
    logic        stall, mem_done, mem_err;
    logic [31:0] mem_lData;
    logic        dbg_req, dbg_we;
    logic [31:0] dbg_addr, dbg_wdata;
    logic        dbg_gnt, dbg_done, dbg_err;
    logic [31:0] dbg_rdata;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_err;

    int tests = 0;
    int fails = 0;

    dmem_access_ctrl #(.AW(32), .DW(32), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .mem_isValid(mem_isValid), .mem_mem_read(mem_mem_read),
        .mem_mem_write(mem_mem_write), .mem_addr(mem_addr), .mem_sData(mem_sData),
        .stall(stall), .mem_done(mem_done), .mem_err(mem_err), .mem_lData(mem_lData),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_done(dbg_done), .dbg_err(dbg_err), .dbg_rdata(dbg_rdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        mem_isValid = 0; mem_mem_read = 0; mem_mem_write = 0;
        mem_addr = 0; mem_sData = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
        bus_ack = 0; bus_rdata = 0;
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1; clear_inputs();
        @(negedge clk); reset = 0;
    endtask

    task automatic cpu_op(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        mem_isValid = 1; mem_mem_read = rd; mem_mem_write = wr; mem_addr = a; mem_sData = d;
    endtask

    typedef struct {
        logic v, rd, wr, dreq, dwe;
        logic e_stall, e_gnt, e_breq, e_bwe;
        logic [31:0] e_addr;
    } vec_t;
    vec_t tbl[8];

    // Random-run model: transaction phase 0 free, 1 on the bus, 2 response cycle.
    int          m_phase, m_acc, m_delay;
    bit          m_owner_dbg, m_last_dbg, m_we, win_dbg, cpu_req_now, cpu_busy;
    logic [31:0] m_addr, m_wdata, m_ldata, m_rdata;
    int          dbg_st;
    int          r;

    initial begin
        reset = 1; clear_inputs();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_bus_req", bus_req, 0);
        chk("rst_done_err", {mem_done, mem_err, dbg_done, dbg_err, bus_err}, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_lData", mem_lData, 0);
        chk("rst_rdata", dbg_rdata, 0);
        reset = 0;

        // ---------------- vector table: IDLE decode after reset ----------------
        tbl[0] = '{0,1,0,0,0, 0,0,0,0, 32'h0};
        tbl[1] = '{1,1,0,0,0, 1,0,1,0, 32'h100};
        tbl[2] = '{1,0,1,0,0, 1,0,1,1, 32'h100};
        tbl[3] = '{0,1,0,1,1, 0,1,1,1, 32'h300};
        tbl[4] = '{1,0,0,1,0, 0,1,1,0, 32'h300};
        tbl[5] = '{1,1,0,1,1, 1,0,1,0, 32'h100};
        tbl[6] = '{0,0,0,0,0, 0,0,0,0, 32'h0};
        tbl[7] = '{1,1,1,1,0, 1,0,1,1, 32'h100};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            mem_isValid = tbl[i].v; mem_mem_read = tbl[i].rd; mem_mem_write = tbl[i].wr;
            mem_addr = 32'h100; mem_sData = 32'hA5A5;
            dbg_req = tbl[i].dreq; dbg_we = tbl[i].dwe; dbg_addr = 32'h300; dbg_wdata = 32'h5A5A;
            #1;
            chk("vec_stall", stall, tbl[i].e_stall);
            chk("vec_dbg_gnt", dbg_gnt, tbl[i].e_gnt);
            @(negedge clk); #1;
            chk("vec_bus_req", bus_req, tbl[i].e_breq);
            chk("vec_bus_we", bus_we, tbl[i].e_bwe);
            chk("vec_bus_addr", bus_addr, tbl[i].e_addr);
            $display("[TB] vector %0d stall=%0b gnt=%0b bus_req=%0b", i, tbl[i].e_stall, tbl[i].e_gnt, tbl[i].e_breq);
            do_reset();
        end

        // ---------------- load, ack in first ACC cycle ----------------
        @(negedge clk); cpu_op(1, 0, 32'h100, 0); #1;
        chk("ld_stall_idle", stall, 1);
        @(negedge clk); bus_ack = 1; bus_rdata = 32'hCAFEF00D; #1;
        chk("ld_stall_acc", stall, 1);
        chk("ld_bus", {bus_req, bus_we, bus_addr}, {1'b1, 1'b0, 32'h100});
        @(negedge clk); bus_ack = 0; #1;
        chk("ld_done", {mem_done, mem_err, stall, bus_req}, 4'b1000);
        chk("ld_data", mem_lData, 32'hCAFEF00D);
        @(negedge clk); clear_inputs(); #1;
        chk("ld_done_pulse", mem_done, 0);
        $display("[TB] load 0x100 -> %0h", mem_lData);

        // ---------------- store, ack after 3 cycles ----------------
        @(negedge clk); cpu_op(0, 1, 32'h200, 32'h12345678); #1;
        chk("st_stall_idle", stall, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); bus_ack = (k == 3); #1;
            chk("st_bus", {bus_req, bus_we, bus_addr, bus_wdata}, {1'b1, 1'b1, 32'h200, 32'h12345678});
            chk("st_wait", {mem_done, stall}, 2'b01);
        end
        @(negedge clk); bus_ack = 0; #1;
        chk("st_done", {mem_done, stall, bus_req}, 3'b100);
        chk("st_lData_kept", mem_lData, 32'hCAFEF00D);
        @(negedge clk); clear_inputs(); #1;
        chk("st_done_once", mem_done, 0);
        $display("[TB] store 0x12345678 @0x200 done");

        // ---------------- timeout abort ----------------
        @(negedge clk); cpu_op(1, 0, 32'h400, 0);
        for (int k = 0; k < 15; k++) begin
            @(negedge clk); #1;
            chk("to_waiting", {bus_req, bus_err, mem_done}, 3'b100);
        end
        @(negedge clk); #1;
        chk("to_abort", {bus_req, bus_err, mem_done, mem_err}, 4'b0111);
        chk("to_lData", mem_lData, 0);
        @(negedge clk); clear_inputs(); #1;
        chk("to_pulse", {bus_err, mem_err, mem_done}, 0);
        $display("[TB] load 0x400 timed out");

        // ---------------- reset in second ACC cycle ----------------
        @(negedge clk); cpu_op(1, 0, 32'h500, 0);
        @(negedge clk); #1; chk("rs_acc1", bus_req, 1);
        @(negedge clk); reset = 1;
        @(negedge clk); reset = 0; bus_ack = 1; bus_rdata = 32'hDEAD; #1;
        chk("rs_idle", {bus_req, mem_done, stall}, 3'b001);
        @(negedge clk); bus_ack = 1; bus_rdata = 32'h55; #1;
        chk("rs_reissue", {bus_req, mem_done, bus_addr}, {1'b1, 1'b0, 32'h500});
        @(negedge clk); bus_ack = 0; #1;
        chk("rs_done", {mem_done, mem_lData}, {1'b1, 32'h55});
        @(negedge clk); clear_inputs();
        $display("[TB] reset mid-access, reissued load -> %0h", 32'h55);

        // ---------------- arbitration ties ----------------
        do_reset();
        @(negedge clk); cpu_op(1, 0, 32'h600, 0);
        dbg_req = 1; dbg_we = 0; dbg_addr = 32'h700; #1;
        chk("arb_tie1_gnt", {dbg_gnt, stall}, 2'b01);
        @(negedge clk); bus_ack = 1; bus_rdata = 32'h1; #1;
        chk("arb_cpu_addr", bus_addr, 32'h600);
        @(negedge clk); bus_ack = 0; #1;
        chk("arb_cpu_done", {mem_done, dbg_gnt}, 2'b10);
        @(negedge clk); mem_addr = 32'h604; #1;
        chk("arb_tie2_gnt", {dbg_gnt, stall}, 2'b11);
        @(negedge clk); dbg_req = 0; bus_ack = 1; bus_rdata = 32'h2; #1;
        chk("arb_dbg_addr", {bus_addr, stall}, {32'h700, 1'b1});
        @(negedge clk); bus_ack = 0; dbg_req = 1; dbg_addr = 32'h704; #1;
        chk("arb_dbg_done", {dbg_done, dbg_rdata, stall}, {1'b1, 32'h2, 1'b1});
        @(negedge clk); #1;
        chk("arb_tie3_gnt", dbg_gnt, 0);
        @(negedge clk); bus_ack = 1; bus_rdata = 32'h3; #1;
        chk("arb_cpu2_addr", bus_addr, 32'h604);
        @(negedge clk); bus_ack = 0; #1;
        chk("arb_cpu2_done", {mem_done, mem_lData}, {1'b1, 32'h3});
        @(negedge clk); mem_isValid = 0; #1;
        chk("arb_dbg_alone", dbg_gnt, 1);
        $display("[TB] arbitration: cpu, dbg, cpu, dbg");
        do_reset();

        // ---------------- randomized run against protocol model ----------------
        m_phase = 0; m_last_dbg = 1; m_ldata = 0; m_rdata = 0;
        cpu_busy = 0; dbg_st = 0; m_acc = 0; m_delay = 0;
        m_owner_dbg = 0; m_we = 0; m_addr = 0; m_wdata = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            chk("rnd_bus_req", bus_req, m_phase == 1);
            if (m_phase == 1)
                chk("rnd_bus_hold", {bus_we, bus_addr, bus_wdata}, {m_we, m_addr, m_wdata});
            chk("rnd_mem_done", mem_done, m_phase == 2 && !m_owner_dbg);
            chk("rnd_dbg_done", dbg_done, m_phase == 2 && m_owner_dbg);
            chk("rnd_errs", {bus_err, mem_err, dbg_err}, 0);
            if (m_phase == 2) begin
                if (m_owner_dbg) begin
                    chk("rnd_dbg_rdata", dbg_rdata, m_rdata);
                    $display("[TB] dbg %s addr=%h data=%h", m_we ? "wr" : "rd", m_addr, m_we ? m_wdata : m_rdata);
                end else begin
                    chk("rnd_lData", mem_lData, m_ldata);
                    $display("[TB] cpu %s addr=%h data=%h", m_we ? "wr" : "rd", m_addr, m_we ? m_wdata : m_ldata);
                end
            end

            if (!cpu_busy) begin
                r = $urandom_range(0, 7);
                if (r == 0) begin
                    mem_isValid = 0; mem_mem_read = 1'($urandom); mem_mem_write = 1'($urandom);
                end else if (r == 1) begin
                    mem_isValid = 1; mem_mem_read = 0; mem_mem_write = 0;
                end else begin
                    cpu_op(r < 5, r >= 5, $urandom, $urandom);
                    cpu_busy = 1;
                end
            end
            if (dbg_st == 0 && $urandom_range(0, 3) == 0) begin
                dbg_req = 1; dbg_we = 1'($urandom); dbg_addr = $urandom; dbg_wdata = $urandom;
                dbg_st = 1;
            end else if (dbg_st != 1) begin
                dbg_req = 0;
            end
            bus_ack   = (m_phase == 1) ? (m_acc == m_delay) : ($urandom_range(0, 3) == 0);
            bus_rdata = $urandom;
            #1;

            cpu_req_now = mem_isValid & (mem_mem_read | mem_mem_write);
            win_dbg     = dbg_req && (!cpu_req_now || !m_last_dbg);
            chk("rnd_stall", stall, cpu_req_now && !(m_phase == 2 && !m_owner_dbg));
            chk("rnd_dbg_gnt", dbg_gnt, m_phase == 0 && win_dbg);

            // Advance the model across the coming rising edge.
            case (m_phase)
                0: if (cpu_req_now || dbg_req) begin
                    m_owner_dbg = win_dbg; m_last_dbg = win_dbg;
                    m_phase = 1; m_acc = 0; m_delay = $urandom_range(0, 5);
                    if (win_dbg) begin
                        m_we = dbg_we; m_addr = dbg_addr; m_wdata = dbg_wdata; dbg_st = 2;
                    end else begin
                        m_we = mem_mem_write; m_addr = mem_addr; m_wdata = mem_sData;
                    end
                end
                1: if (bus_ack) begin
                    m_phase = 2;
                    if (!m_we) begin
                        if (m_owner_dbg) m_rdata = bus_rdata;
                        else             m_ldata = bus_rdata;
                    end
                end else begin
                    m_acc++;
                end
                default: begin
                    m_phase = 0;
                    if (m_owner_dbg) dbg_st = 0;
                    else             cpu_busy = 0;
                end
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
